seat_query_reader: RTL and testbench
====================================

Name: seat_query_reader

Overview:
Read-side responder for the seat table maintained by the seating system. A write port updates the table with student number, seat number and seat state; this block serves queries against that table over a valid/ready interface. It supports three queries: look up a seat, find the seat held by a student, and count occupied seats. It reads the table through a single registered read port with 1-cycle latency and returns one result per query.

Parameters:
NUM_SEATS, 32, number of seats, 1..32; valid seats are 0..NUM_SEATS-1
SEAT_W, 5, seat number width
SNO_W, 32, student number width
CNT_W, 6, occupancy count width, >= clog2(NUM_SEATS+1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
q_valid  in  1  query valid
q_ready  out  1  block can accept a query
q_mode  in  2  0 BY_SEAT, 1 BY_STUDENT, 2 COUNT, 3 reserved
q_seat  in  SEAT_W  seat for BY_SEAT
q_student  in  SNO_W  student for BY_STUDENT
tbl_rd_en  out  1  table read strobe
tbl_rd_addr  out  SEAT_W  table read address
tbl_rd_student  in  SNO_W  holder of addressed seat, valid the cycle after tbl_rd_en
tbl_rd_state  in  2  state of addressed seat (0 FREE, 1 AWAY, 2 OCCUPIED, 3 invalid), same timing
r_valid  out  1  result valid
r_ready  in  1  result consumed
r_found  out  1  hit / seat in use
r_seat  out  SEAT_W  matched or queried seat
r_student  out  SNO_W  holder student number
r_state  out  2  holder seat state
r_count  out  CNT_W  number of non-FREE seats (COUNT mode)

Behaviour:
- Reset (async, rst_n=0): state IDLE; q_ready, r_valid, r_found, tbl_rd_en = 0; r_seat, r_student, r_state, r_count and the scan index = 0. Reset asserted mid-scan or mid-response aborts that operation with no response. q_ready rises on the first clk edge after rst_n deasserts.
- FSM states IDLE, RD, CMP, RESP. In IDLE, q_ready=1. All other states have q_ready=0.
- Accept: q_valid & q_ready at edge E0. The block latches the mode, seat and student, clears the index and count, and moves to RD.
- RD: tbl_rd_en=1 and tbl_rd_addr=index (BY_SEAT: the latched q_seat). Next state is CMP.
- CMP: the block evaluates the table data.
  - A seat is in use when tbl_rd_state is 1 or 2. State 3 is treated as FREE.
  - BY_SEAT: r_found = in use. r_student/r_state are loaded from the table. Go to RESP.
  - BY_STUDENT: the seat matches when in use and tbl_rd_student == q_student. On a match, load r_*, set r_found=1 and go to RESP. On no match with index == NUM_SEATS-1, set r_found=0, r_student=q_student, r_state=0 and go to RESP. Otherwise increment the index and go to RD.
  - COUNT: increment the count when the seat is in use. At the last seat go to RESP with r_found=(count>0) and r_count=final count; otherwise go to RD.
- Latency: BY_SEAT r_valid is high after E2. BY_STUDENT with a hit at seat i: high after E(2i+2). Miss or COUNT: high after E(2*NUM_SEATS). The lowest-numbered matching seat wins.
- q_student == 0 never matches; the block still scans and reports a miss.
- BY_SEAT with q_seat >= NUM_SEATS, or q_mode=3: no table read. Go to RESP at E1 with r_found=0 and r_seat=q_seat.
- RESP: r_valid=1 and all r_* held stable until r_valid & r_ready. On that edge, r_valid=0 and the FSM returns to IDLE.
  - q_ready rises on the following edge, giving one dead cycle. There is no back-to-back overlap.
- tbl_rd_en is high only in RD. tbl_rd_addr holds its value otherwise.
- r_ready while r_valid=0 is ignored. q_valid outside IDLE is ignored; the query is not queued.
- Table writes during a scan are not blocked. Each seat is sampled once, so the result reflects per-seat read-time values.

Test Plan:
- Table seat1={201819186,2}, seat2={201912352,1}, seat5={201918757,2}, others FREE. BY_SEAT q_seat=1 -> r_valid 2 cycles after accept, r_found=1, r_student=201819186, r_state=2.
- BY_STUDENT q_student=201918757 -> r_seat=5, r_state=2, r_valid 12 cycles after accept. BY_STUDENT q_student=201912379 -> r_found=0 after 64 cycles.
- COUNT on the same table -> r_count=3, r_found=1. After seat1 is written to state 0, COUNT -> r_count=2.
- r_ready held low 10 cycles in RESP -> r_valid and r_* stable, q_ready=0, a new q_valid is ignored. r_ready=1 -> r_valid drops on that edge and q_ready=1 one edge later.
- NUM_SEATS=20, BY_SEAT q_seat=25 -> tbl_rd_en never asserted, r_found=0 one cycle after accept. q_mode=3 -> same response.
- rst_n pulsed low during a BY_STUDENT scan at index 7 -> outputs zero immediately and no result is produced. A fresh BY_SEAT q_seat=2 then returns 201912352 with state 1.

Source files
------------

// File: rtl/seat_query_reader_if.sv
// ---------------------------------------------------------------------------
// seat_query_reader_if
//   Bundles the three buses of the seat-table query responder:
//     query   : q_valid/q_ready handshake with q_mode, q_seat, q_student
//     table   : tbl_rd_en/tbl_rd_addr strobe and tbl_rd_student/tbl_rd_state
//               data returned one cycle after the strobe
//     result  : r_valid/r_ready handshake with r_found, r_seat, r_student,
//               r_state, r_count
//   slave  modport : the responder (seat_query_reader)
//   master modport : the environment (query source, seat table, result sink)
// ---------------------------------------------------------------------------
interface seat_query_reader_if #(
    parameter int SEAT_W = 5,
    parameter int SNO_W  = 32,
    parameter int CNT_W  = 6
);
    // query channel
    logic              q_valid;
    logic              q_ready;
    logic [1:0]        q_mode;
    logic [SEAT_W-1:0] q_seat;
    logic [SNO_W-1:0]  q_student;

    // seat table read port
    logic              tbl_rd_en;
    logic [SEAT_W-1:0] tbl_rd_addr;
    logic [SNO_W-1:0]  tbl_rd_student;
    logic [1:0]        tbl_rd_state;

    // result channel
    logic              r_valid;
    logic              r_ready;
    logic              r_found;
    logic [SEAT_W-1:0] r_seat;
    logic [SNO_W-1:0]  r_student;
    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_count;

    modport slave (
        input  q_valid, q_mode, q_seat, q_student,
        output q_ready,
        output tbl_rd_en, tbl_rd_addr,
        input  tbl_rd_student, tbl_rd_state,
        output r_valid, r_found, r_seat, r_student, r_state, r_count,
        input  r_ready
    );

    modport master (
        output q_valid, q_mode, q_seat, q_student,
        input  q_ready,
        input  tbl_rd_en, tbl_rd_addr,
        output tbl_rd_student, tbl_rd_state,
        input  r_valid, r_found, r_seat, r_student, r_state, r_count,
        output r_ready
    );
endinterface

// File: rtl/seat_query_reader.sv
// ---------------------------------------------------------------------------
// seat_query_reader
//   Serves queries against the seat table through a single registered read
//   port (data valid the cycle after tbl_rd_en):
//     BY_SEAT    : report holder and state of one seat
//     BY_STUDENT : scan seats from 0 upward for the first in-use seat held by
//                  the student (student number 0 never matches)
//     COUNT      : scan all seats and count the in-use ones (AWAY/OCCUPIED)
//   One query is in flight at a time; a result is held until r_ready.
//   Ports:
//     clk, rst_n : clock and asynchronous active-low reset
//     bus        : query / table / result buses (seat_query_reader_if.slave)
//   The interface instance must use the same SEAT_W, SNO_W and CNT_W.
// ---------------------------------------------------------------------------
module seat_query_reader #(
    parameter int NUM_SEATS = 32,
    parameter int SEAT_W    = 5,
    parameter int SNO_W     = 32,
    parameter int CNT_W     = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    seat_query_reader_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_CMP  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        M_BY_SEAT    = 2'd0,
        M_BY_STUDENT = 2'd1,
        M_COUNT      = 2'd2,
        M_RESERVED   = 2'd3
    } mode_t;

    localparam logic [1:0]        SEAT_AWAY     = 2'd1;
    localparam logic [1:0]        SEAT_OCCUPIED = 2'd2;
    localparam logic [SEAT_W:0]   SEAT_LIMIT    = (SEAT_W+1)'(NUM_SEATS);
    localparam logic [SEAT_W-1:0] LAST_IDX      = SEAT_W'(NUM_SEATS - 1);

    state_t             state, next_state;
    mode_t              mode_q;
    logic               skip_q;      // query answered without a table read
    logic               q_ready_q;
    logic [SEAT_W-1:0]  seat_q;
    logic [SNO_W-1:0]   student_q;
    logic [SEAT_W-1:0]  index;
    logic [SEAT_W-1:0]  addr_q;
    logic [CNT_W-1:0]   cnt;
    logic               r_found_q;
    logic [SEAT_W-1:0]  r_seat_q;
    logic [SNO_W-1:0]   r_student_q;
    logic [1:0]         r_state_q;

    logic seat_in_range;
    logic skip_in;
    logic accept;
    logic in_use;
    logic hit;
    logic last;

    assign seat_in_range = ({1'b0, bus.q_seat} < SEAT_LIMIT);
    assign skip_in       = (mode_t'(bus.q_mode) == M_RESERVED) ||
                           ((mode_t'(bus.q_mode) == M_BY_SEAT) && !seat_in_range);
    assign accept        = (state == S_IDLE) && q_ready_q && bus.q_valid;

    // State 3 on the table is treated as FREE.
    assign in_use = (bus.tbl_rd_state == SEAT_AWAY) || (bus.tbl_rd_state == SEAT_OCCUPIED);
    assign hit    = in_use && (student_q != '0) && (bus.tbl_rd_student == student_q);
    assign last   = (index == LAST_IDX);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, matching real hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state is given its default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    next_state = skip_in ? S_CMP : S_RD;
                end
            end
            S_RD: begin
                next_state = S_CMP;
            end
            S_CMP: begin
                if (skip_q) begin
                    next_state = S_RESP;
                end else begin
                    unique case (mode_q)
                        M_BY_STUDENT: next_state = (hit || last) ? S_RESP : S_RD;
                        M_COUNT:      next_state = last ? S_RESP : S_RD;
                        default:      next_state = S_RESP;
                    endcase
                end
            end
            S_RESP: begin
                if (bus.r_ready) begin
                    next_state = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_ready_q   <= 1'b0;
            mode_q      <= M_BY_SEAT;
            skip_q      <= 1'b0;
            seat_q      <= '0;
            student_q   <= '0;
            index       <= '0;
            addr_q      <= '0;
            cnt         <= '0;
            r_found_q   <= 1'b0;
            r_seat_q    <= '0;
            r_student_q <= '0;
            r_state_q   <= '0;
        end else begin
            // Registered ready: rises one edge after reset release, and one
            // edge after the result handshake (the dead cycle after RESP).
            q_ready_q <= (state == S_IDLE) && (next_state == S_IDLE);

            if (accept) begin
                mode_q    <= mode_t'(bus.q_mode);
                skip_q    <= skip_in;
                seat_q    <= bus.q_seat;
                student_q <= bus.q_student;
                index     <= '0;
                cnt       <= '0;
                if (!skip_in) begin
                    addr_q <= (mode_t'(bus.q_mode) == M_BY_SEAT) ? bus.q_seat : '0;
                end
            end

            if (state == S_CMP) begin
                if (skip_q) begin
                    r_found_q   <= 1'b0;
                    r_seat_q    <= seat_q;
                    r_student_q <= '0;
                    r_state_q   <= '0;
                end else begin
                    unique case (mode_q)
                        M_BY_SEAT: begin
                            r_found_q   <= in_use;
                            r_seat_q    <= seat_q;
                            r_student_q <= bus.tbl_rd_student;
                            r_state_q   <= bus.tbl_rd_state;
                        end
                        M_BY_STUDENT: begin
                            if (hit) begin
                                r_found_q   <= 1'b1;
                                r_seat_q    <= index;
                                r_student_q <= bus.tbl_rd_student;
                                r_state_q   <= bus.tbl_rd_state;
                            end else if (last) begin
                                r_found_q   <= 1'b0;
                                r_seat_q    <= index;
                                r_student_q <= student_q;
                                r_state_q   <= '0;
                            end else begin
                                index  <= index + SEAT_W'(1);
                                addr_q <= index + SEAT_W'(1);
                            end
                        end
                        M_COUNT: begin
                            cnt <= cnt + CNT_W'(in_use);
                            if (last) begin
                                // Include the seat being evaluated right now.
                                r_found_q <= (cnt != '0) || in_use;
                                r_seat_q  <= index;
                            end else begin
                                index  <= index + SEAT_W'(1);
                                addr_q <= index + SEAT_W'(1);
                            end
                        end
                        default: begin
                            r_found_q <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.q_ready     = q_ready_q;
    assign bus.tbl_rd_en   = (state == S_RD);
    assign bus.tbl_rd_addr = addr_q;
    assign bus.r_valid     = (state == S_RESP);
    assign bus.r_found     = r_found_q;
    assign bus.r_seat      = r_seat_q;
    assign bus.r_student   = r_student_q;
    assign bus.r_state     = r_state_q;
    assign bus.r_count     = cnt;

endmodule

// File: tb/tb_seat_query_reader.sv
// ---------------------------------------------------------------------------
// tb_seat_query_reader
//   Scoreboard bench for seat_query_reader. The bench owns the seat table
//   (a registered-read memory), issues queries, and at each accepted query
//   pushes the answer computed from the table contents by a reference model.
//   A monitor pops and compares whenever the DUT presents a result, including
//   response latency and the number of table reads spent.
// ---------------------------------------------------------------------------
module tb_seat_query_reader;

    localparam int NUM_SEATS = 20;
    localparam int SEAT_W    = 5;
    localparam int SNO_W     = 32;
    localparam int CNT_W     = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seat_query_reader_if #(.SEAT_W(SEAT_W), .SNO_W(SNO_W), .CNT_W(CNT_W)) sq_if ();

    seat_query_reader #(
        .NUM_SEATS(NUM_SEATS),
        .SEAT_W   (SEAT_W),
        .SNO_W    (SNO_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (sq_if)
    );

    // ---------------- seat table (environment) ----------------
    logic [SNO_W-1:0] tbl_stu [32];
    logic [1:0]       tbl_st  [32];

    always @(posedge clk) begin
        if (sq_if.tbl_rd_en) begin
            sq_if.tbl_rd_student <= tbl_stu[sq_if.tbl_rd_addr];
            sq_if.tbl_rd_state   <= tbl_st[sq_if.tbl_rd_addr];
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic              found;
        logic [SEAT_W-1:0] seat;
        logic [SNO_W-1:0]  student;
        logic [1:0]        state;
        logic [CNT_W-1:0]  count;
        bit                chk_seat;
        bit                chk_ss;
        bit                chk_cnt;
        int                lat;
        int                reads;
    } exp_t;

    function automatic bit seat_used(input int i);
        return (tbl_st[i] == 2'd1) || (tbl_st[i] == 2'd2);
    endfunction

    function automatic exp_t model(input logic [1:0] m, input logic [SEAT_W-1:0] s,
                                   input logic [SNO_W-1:0] stu);
        exp_t e;
        int   hit_at;
        int   n;
        e = '{found: 1'b0, seat: s, student: '0, state: '0, count: '0,
              chk_seat: 1'b1, chk_ss: 1'b0, chk_cnt: 1'b0, lat: 1, reads: 0};
        if (m == 2'd3 || (m == 2'd0 && int'(s) >= NUM_SEATS)) begin
            return e;
        end
        case (m)
            2'd0: begin
                e.found   = seat_used(int'(s));
                e.student = tbl_stu[s];
                e.state   = tbl_st[s];
                e.chk_ss  = 1'b1;
                e.lat     = 2;
                e.reads   = 1;
            end
            2'd1: begin
                hit_at = -1;
                for (int i = NUM_SEATS - 1; i >= 0; i--) begin
                    if (stu != 0 && seat_used(i) && tbl_stu[i] == stu) hit_at = i;
                end
                e.chk_ss = 1'b1;
                if (hit_at >= 0) begin
                    e.found   = 1'b1;
                    e.seat    = SEAT_W'(hit_at);
                    e.student = tbl_stu[hit_at];
                    e.state   = tbl_st[hit_at];
                    e.lat     = 2 * hit_at + 2;
                    e.reads   = hit_at + 1;
                end else begin
                    e.chk_seat = 1'b0;
                    e.student  = stu;
                    e.state    = 2'd0;
                    e.lat      = 2 * NUM_SEATS;
                    e.reads    = NUM_SEATS;
                end
            end
            default: begin
                n = 0;
                for (int i = 0; i < NUM_SEATS; i++) n += int'(seat_used(i));
                e.chk_seat = 1'b0;
                e.chk_cnt  = 1'b1;
                e.count    = CNT_W'(n);
                e.found    = (n > 0);
                e.lat      = 2 * NUM_SEATS;
                e.reads    = NUM_SEATS;
            end
        endcase
        return e;
    endfunction

    // ---------------- bookkeeping ----------------
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   rd_cnt = 0;
    int   n_acc = 0;
    int   n_resp = 0;
    int   n_abort = 0;
    bit   seen = 1'b0;
    bit   manual_rr = 1'b0;
    exp_t sb[$];
    exp_t cur;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Accept logger / read counter: sees pre-edge values at every rising edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n) begin
            if (sq_if.q_valid && sq_if.q_ready) begin
                sb.push_back(model(sq_if.q_mode, sq_if.q_seat, sq_if.q_student));
                acc_cyc = cyc;
                rd_cnt  = 0;
                n_acc++;
            end
            if (sq_if.tbl_rd_en) rd_cnt++;
            if (sq_if.r_valid && sq_if.r_ready) seen = 1'b0;
        end
    end

    // Monitor: compares every cycle a result is presented (covers stability).
    always @(negedge clk) begin
        if (rst_n && sq_if.r_valid) begin
            if (!seen) begin
                check("result_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    cur = sb.pop_front();
                    seen = 1'b1;
                    n_resp++;
                    check("latency", cyc - acc_cyc, cur.lat);
                    check("table_reads", rd_cnt, cur.reads);
                end
            end
            if (seen) begin
                check("r_found", sq_if.r_found, cur.found);
                if (cur.chk_seat) check("r_seat", sq_if.r_seat, cur.seat);
                if (cur.chk_ss) begin
                    check("r_student", sq_if.r_student, cur.student);
                    check("r_state", sq_if.r_state, cur.state);
                end
                if (cur.chk_cnt) check("r_count", sq_if.r_count, cur.count);
                check("q_ready_in_resp", sq_if.q_ready, 0);
            end
        end
    end

    // Random result backpressure unless a test drives r_ready by hand.
    initial begin
        sq_if.r_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!manual_rr) sq_if.r_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [1:0] m, input logic [SEAT_W-1:0] s,
                         input logic [SNO_W-1:0] stu);
        @(negedge clk);
        sq_if.q_mode    = m;
        sq_if.q_seat    = s;
        sq_if.q_student = stu;
        sq_if.q_valid   = 1'b1;
        for (int i = 0; i < 100 && !sq_if.q_ready; i++) @(negedge clk);
        check("q_ready_wait", sq_if.q_ready, 1);
        @(posedge clk);
        #1;
        sq_if.q_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (n_resp == n_acc - n_abort && !sq_if.r_valid) break;
        end
        check("response_count", n_resp, n_acc - n_abort);
    endtask

    task automatic query(input logic [1:0] m, input logic [SEAT_W-1:0] s,
                         input logic [SNO_W-1:0] stu);
        issue(m, s, stu);
        wait_done();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_q_ready"}, sq_if.q_ready, 0);
        check({tag, "_r_valid"}, sq_if.r_valid, 0);
        check({tag, "_tbl_rd_en"}, sq_if.tbl_rd_en, 0);
        check({tag, "_tbl_rd_addr"}, sq_if.tbl_rd_addr, 0);
        check({tag, "_r_found"}, sq_if.r_found, 0);
        check({tag, "_r_seat"}, sq_if.r_seat, 0);
        check({tag, "_r_student"}, sq_if.r_student, 0);
        check({tag, "_r_state"}, sq_if.r_state, 0);
        check({tag, "_r_count"}, sq_if.r_count, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        sq_if.q_valid   = 1'b0;
        sq_if.q_mode    = '0;
        sq_if.q_seat    = '0;
        sq_if.q_student = '0;
        for (int i = 0; i < 32; i++) begin
            tbl_stu[i] = '0;
            tbl_st[i]  = 2'd0;
        end

        // reset behaviour
        #22;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("q_ready_before_edge", sq_if.q_ready, 0);
        @(posedge clk);
        #1;
        check("q_ready_after_edge", sq_if.q_ready, 1);

        // directed table
        tbl_stu[1] = 32'd201819186; tbl_st[1] = 2'd2;
        tbl_stu[2] = 32'd201912352; tbl_st[2] = 2'd1;
        tbl_stu[5] = 32'd201918757; tbl_st[5] = 2'd2;

        query(2'd0, 5'd1, '0);
        query(2'd1, '0, 32'd201918757);
        query(2'd1, '0, 32'd201912379);
        query(2'd2, '0, '0);
        tbl_st[1] = 2'd0;
        query(2'd2, '0, '0);
        tbl_st[1] = 2'd2;

        // boundaries: out-of-range seat, reserved mode, first/last seat,
        // state 3 treated as FREE, student 0, duplicate holder, empty count
        query(2'd0, 5'd25, '0);
        query(2'd3, 5'd7, 32'd201819186);
        query(2'd0, 5'd0, '0);
        tbl_stu[19] = 32'd777; tbl_st[19] = 2'd1;
        query(2'd0, 5'd19, '0);
        query(2'd1, '0, 32'd777);
        tbl_stu[3] = 32'd0; tbl_st[3] = 2'd2;
        query(2'd1, '0, 32'd0);
        tbl_stu[4] = 32'd777; tbl_st[4] = 2'd3;
        query(2'd0, 5'd4, '0);
        query(2'd1, '0, 32'd777);
        tbl_st[4] = 2'd2;
        query(2'd1, '0, 32'd777);
        for (int i = 0; i < 32; i++) tbl_st[i] = 2'd0;
        query(2'd2, '0, '0);
        tbl_stu[1] = 32'd201819186; tbl_st[1] = 2'd2;
        tbl_stu[2] = 32'd201912352; tbl_st[2] = 2'd1;
        tbl_stu[5] = 32'd201918757; tbl_st[5] = 2'd2;

        // result held under backpressure; new queries ignored meanwhile
        @(negedge clk);
        manual_rr = 1'b1;
        sq_if.r_ready = 1'b0;
        issue(2'd0, 5'd2, '0);
        for (int i = 0; i < 50 && !sq_if.r_valid; i++) @(negedge clk);
        check("hold_r_valid", sq_if.r_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sq_if.q_mode  = 2'd2;
            sq_if.q_valid = 1'b1;
            check("hold_r_valid_stable", sq_if.r_valid, 1);
        end
        @(negedge clk);
        sq_if.q_valid = 1'b0;
        sq_if.r_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_r_valid", sq_if.r_valid, 0);
        check("dead_cycle_q_ready", sq_if.q_ready, 0);
        @(posedge clk);
        #1;
        check("q_ready_after_dead", sq_if.q_ready, 1);
        manual_rr = 1'b0;
        wait_done();

        // reset in the middle of a BY_STUDENT scan at index 7
        issue(2'd1, '0, 32'd201912379);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sq_if.tbl_rd_en && sq_if.tbl_rd_addr == 5'd7) break;
        end
        check("scan_reached_7", sq_if.tbl_rd_addr, 7);
        rst_n = 1'b0;
        sb.delete();
        n_abort++;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("no_result_after_abort", n_resp, n_acc - n_abort);
        query(2'd0, 5'd2, '0);

        // randomized tables and queries
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 32; i++) begin
                tbl_st[i]  = 2'($urandom_range(0, 3));
                tbl_stu[i] = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'd1000 + $urandom_range(1, 5);
            end
            query(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 6) == 0) ? 32'd0 : 32'd1000 + $urandom_range(1, 7));
        end

        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

endmodule
